// File: rtl/stim_check_i8.sv
// stim_check_i8: LFSR-driven stimulus generator and result checker for a downstream 8-bit AND stage.
// Each vector drives a/b, waits LATENCY+1 cycles, compares y against a&b and tallies mismatches.
module stim_check_i8 #(
  parameter int         N_VECTORS = 16,
  parameter int         LATENCY   = 1,
  parameter logic [7:0] SEED_A    = 8'h03,
  parameter logic [7:0] SEED_B    = 8'h5A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  a,
  output logic [7:0]  b,
  input  logic [7:0]  y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] fail_index
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left with feedback into bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

  localparam logic [7:0]  LP_SEED_A = fix_seed(SEED_A);
  localparam logic [7:0]  LP_SEED_B = fix_seed(SEED_B);
  localparam logic [15:0] LP_LAST   = 16'(N_VECTORS - 1);
  localparam logic [3:0]  LP_LAT    = 4'(LATENCY);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_lfsr_a;
  logic [7:0]  r_lfsr_b;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_err;
  logic [15:0] r_fail;
  logic [15:0] r_vec;
  logic [3:0]  r_lat;
  logic        w_load;
  logic        w_drive;
  logic        w_check;
  logic        w_mismatch;
  logic        w_last;

  assign w_mismatch = (y != (r_a & r_b));
  assign w_last     = (r_vec == LP_LAST);

  assign a          = r_a;
  assign b          = r_b;
  assign err_count  = r_err;
  assign fail_index = r_fail;
  assign busy       = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done       = (r_state == S_DONE);
  assign pass       = (r_state == S_DONE) && (r_err == 8'h00);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drive     = 1'b0;
    w_check     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_drive     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_lat == LP_LAT) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_check     = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_DRIVE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr_a <= LP_SEED_A;
      r_lfsr_b <= LP_SEED_B;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_err    <= 8'h00;
      r_fail   <= 16'hFFFF;
      r_vec    <= 16'h0000;
      r_lat    <= 4'h0;
    end else begin
      if (w_load) begin
        r_lfsr_a <= LP_SEED_A;
        r_lfsr_b <= LP_SEED_B;
        r_vec    <= 16'h0000;
        r_err    <= 8'h00;
        r_fail   <= 16'hFFFF;
      end
      if (w_drive) begin
        r_a   <= r_lfsr_a;
        r_b   <= r_lfsr_b;
        r_lat <= 4'h0;
      end
      if (r_state == S_WAIT) r_lat <= r_lat + 4'h1;
      // Only the first mismatch of a run is recorded in fail_index.
      if (w_check) begin
        if (w_mismatch) begin
          r_err <= sat_inc(r_err);
          if (r_fail == 16'hFFFF) r_fail <= r_vec;
        end
        r_lfsr_a <= lfsr_step(r_lfsr_a);
        r_lfsr_b <= lfsr_step(r_lfsr_b);
        if (!w_last) r_vec <= r_vec + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_stim_check_i8.sv
// Scoreboard bench for stim_check_i8: three instances with mock AND stages (clean, corrupted, inverted).
// Expected run results are queued at each start and popped by a monitor whenever done rises.
module tb_stim_check_i8;

  localparam int         N0  = 4;
  localparam int         L0  = 1;
  localparam int         N1  = 300;
  localparam int         L1  = 0;
  localparam int         N2  = 255;
  localparam int         L2  = 2;
  localparam logic [7:0] SA0 = 8'h03;
  localparam logic [7:0] SB0 = 8'h5A;
  localparam logic [7:0] SA2 = 8'h00;

  typedef struct {
    int id;
    int err;
    int fail;
    int pss;
    int done_cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        sv    [3];
  logic [7:0]  av    [3];
  logic [7:0]  bv    [3];
  logic [7:0]  yv    [3];
  logic [7:0]  ev    [3];
  logic [15:0] fv    [3];
  logic        busyv [3];
  logic        donev [3];
  logic        passv [3];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t q[$];

  logic [7:0] ra0 [N0];
  logic [7:0] rb0 [N0];
  logic [7:0] mask0 [N0];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  stim_check_i8 #(.N_VECTORS(N0), .LATENCY(L0), .SEED_A(SA0), .SEED_B(SB0)) u0 (
    .clock(clock), .reset(reset), .start(sv[0]), .a(av[0]), .b(bv[0]), .y(yv[0]),
    .busy(busyv[0]), .done(donev[0]), .pass(passv[0]), .err_count(ev[0]), .fail_index(fv[0]));
  stim_check_i8 #(.N_VECTORS(N1), .LATENCY(L1), .SEED_A(SA0), .SEED_B(SB0)) u1 (
    .clock(clock), .reset(reset), .start(sv[1]), .a(av[1]), .b(bv[1]), .y(yv[1]),
    .busy(busyv[1]), .done(donev[1]), .pass(passv[1]), .err_count(ev[1]), .fail_index(fv[1]));
  stim_check_i8 #(.N_VECTORS(N2), .LATENCY(L2), .SEED_A(SA2), .SEED_B(SB0)) u2 (
    .clock(clock), .reset(reset), .start(sv[2]), .a(av[2]), .b(bv[2]), .y(yv[2]),
    .busy(busyv[2]), .done(donev[2]), .pass(passv[2]), .err_count(ev[2]), .fail_index(fv[2]));

  // Reference LFSR: doubling modulo 256 plus the parity of the tapped bits 7,5,4,3.
  function automatic logic [7:0] step(input logic [7:0] s);
    return 8'(((2 * int'(s)) % 256) + ($countones(s & 8'hB8) % 2));
  endfunction

  function automatic logic [7:0] seed_of(input int id, input bit is_b);
    logic [7:0] s;
    s = is_b ? SB0 : ((id == 2) ? SA2 : SA0);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  function automatic int nvec(input int id);
    return (id == 0) ? N0 : ((id == 1) ? N1 : N2);
  endfunction

  function automatic int lat(input int id);
    return (id == 0) ? L0 : ((id == 1) ? L1 : L2);
  endfunction

  // XOR applied by the mock stage of u0 to the pair of vector k (pairs are unique within a run).
  function automatic logic [7:0] mask_for(input logic [7:0] xa, input logic [7:0] xb);
    for (int k = 0; k < N0; k++)
      if (xa == ra0[k] && xb == rb0[k]) return mask0[k];
    return 8'h00;
  endfunction

  function automatic logic [7:0] corruption(input int id, input int k);
    if (id == 0) return mask0[k];
    if (id == 1) return 8'hFF;
    return 8'h00;
  endfunction

  always @(posedge clock) begin
    yv[0] <= (av[0] & bv[0]) ^ mask_for(av[0], bv[0]);
    yv[1] <= ~(av[1] & bv[1]);
    yv[2] <= av[2] & bv[2];
  end

  task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d %s: got %0h expected %0h", id, name, act, exp);
  endtask

  // done is seen N*(L+3) edges after the edge that samples start, i.e. on edge 1+N*(L+3)
  // counting that sampling edge as edge 1.
  task automatic push_run(input int id, input int sc);
    exp_t e;
    int   cnt;
    cnt = 0;
    e.id = id;
    e.fail = 32'hFFFF;
    for (int k = 0; k < nvec(id); k++)
      if (corruption(id, k) != 8'h00) begin
        cnt++;
        if (e.fail == 32'hFFFF) e.fail = k;
      end
    e.err = (cnt > 255) ? 255 : cnt;
    e.pss = (cnt == 0) ? 1 : 0;
    e.done_cyc = sc + nvec(id) * (lat(id) + 3);
    q.push_back(e);
  endtask

  logic       pd [3];
  logic       pb [3];
  logic       bad [3];
  logic       zero [3];
  int         nobs [3];
  logic [7:0] ma [3];
  logic [7:0] mb [3];
  logic [15:0] pp [3];

  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      pd[i] = 1'b0;
      pb[i] = 1'b0;
      bad[i] = 1'b0;
      zero[i] = 1'b0;
      nobs[i] = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (busyv[i] && !pb[i]) begin
          nobs[i] = 0;
          bad[i]  = 1'b0;
          zero[i] = 1'b0;
          ma[i]   = seed_of(i, 1'b0);
          mb[i]   = seed_of(i, 1'b1);
          pp[i]   = {av[i], bv[i]};
        end
        if (busyv[i] && ({av[i], bv[i]} != pp[i])) begin
          if (av[i] !== ma[i] || bv[i] !== mb[i]) bad[i] = 1'b1;
          if (av[i] == 8'h00) zero[i] = 1'b1;
          nobs[i]++;
          ma[i] = step(ma[i]);
          mb[i] = step(mb[i]);
          pp[i] = {av[i], bv[i]};
        end
        if (donev[i] && !pd[i]) begin
          if (q.size() == 0) begin
            check(i, "unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check(i, "run_owner", i, e.id);
            check(i, "err_count", ev[i], e.err);
            check(i, "fail_index", fv[i], e.fail);
            check(i, "pass", passv[i], e.pss);
            check(i, "done_cycle", cyc, e.done_cyc);
            check(i, "ab_count", nobs[i], nvec(i));
            check(i, "ab_seq_bad", bad[i], 0);
            check(i, "a_zero_seen", zero[i], 0);
          end
        end
        pd[i] = donev[i];
        pb[i] = busyv[i];
      end
    end
  end

  task automatic pulse_start(input int id, output int sc);
    @(negedge clock);
    sv[id] = 1'b1;
    @(posedge clock);
    #1;
    sc = cyc;
    sv[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget);
    int n;
    n = 0;
    while (!donev[id] && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!donev[id]) check(id, "done_timeout", 0, 1);
  endtask

  task automatic check_reset_vals(input int id);
    check(id, "rst_a", av[id], 8'h00);
    check(id, "rst_b", bv[id], 8'h00);
    check(id, "rst_busy", busyv[id], 0);
    check(id, "rst_done", donev[id], 0);
    check(id, "rst_pass", passv[id], 0);
    check(id, "rst_err", ev[id], 8'h00);
    check(id, "rst_fail", fv[id], 16'hFFFF);
  endtask

  task automatic set_masks(input int mode);
    for (int k = 0; k < N0; k++) begin
      if (mode == 2) mask0[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      else           mask0[k] = 8'h00;
    end
    if (mode == 1) mask0[2] = 8'h01;
  endtask

  task automatic run_u0(input int mode);
    int sc;
    set_masks(mode);
    pulse_start(0, sc);
    push_run(0, sc);
    wait_done(0, 100);
  endtask

  initial begin
    int sc;
    ra0[0] = seed_of(0, 1'b0);
    rb0[0] = seed_of(0, 1'b1);
    for (int k = 1; k < N0; k++) begin
      ra0[k] = step(ra0[k-1]);
      rb0[k] = step(rb0[k-1]);
    end
    set_masks(0);
    for (int i = 0; i < 3; i++) sv[i] = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_reset_vals(0);
    check_reset_vals(2);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check(0, "idle_hold_busy", busyv[0], 0);
    check(0, "idle_hold_done", donev[0], 0);

    run_u0(0);
    run_u0(1);
    for (int r = 0; r < 3; r++) run_u0(2);

    // Abort during the WAIT of vector 1, then a full run must replay the same a/b sequence.
    set_masks(2);
    pulse_start(0, sc);
    repeat (5) @(posedge clock);
    #2;
    check(0, "busy_before_reset", busyv[0], 1);
    reset = 1'b0;
    #1 check_reset_vals(0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check(0, "post_reset_idle", busyv[0], 0);
    run_u0(2);

    // start held high across a whole run: restart only from DONE, with counts cleared.
    set_masks(0);
    mask0[1] = 8'h10;
    mask0[3] = 8'h80;
    @(negedge clock);
    sv[0] = 1'b1;
    @(posedge clock);
    #1 sc = cyc;
    push_run(0, sc);
    push_run(0, sc + N0 * (L0 + 3) + 1);
    wait_done(0, 100);
    @(posedge clock);
    #1 sv[0] = 1'b0;
    check(0, "restart_busy", busyv[0], 1);
    wait_done(0, 100);
    repeat (3) @(negedge clock);
    check(0, "done_holds", donev[0], 1);

    pulse_start(1, sc);
    push_run(1, sc);
    wait_done(1, 1200);

    pulse_start(2, sc);
    push_run(2, sc);
    @(posedge clock);
    #1 check(2, "first_a", av[2], 8'h01);
    wait_done(2, 2000);

    repeat (2) @(negedge clock);
    check(0, "queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
